mem_port_arbiter: RTL and testbench

// - Shares the single synchronous-read data memory port between the CPU data path and a debug/loader port.
// - One access per cycle; grant is combinational in the request cycle, read data returns 1 cycle later.
// - Round-robin with a burst limit so neither side starves; sits between Cpu/loader and Memory.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one synchronous-read data memory port between the CPU data
//            path and the debug/loader port. One access per cycle, grant is
//            combinational in the request cycle, read data returns one cycle
//            later. Round-robin with a burst limit so neither side starves.
//            Optional MEM_ARB_STATS_EN adds saturating grant/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_cpu,
  output logic [15:0]   stat_dbg,
  output logic [15:0]   stat_stall
`endif
);

  // Burst counter only needs to reach MAX_BURST; it saturates there.
  localparam int c_cnt_w = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [c_cnt_w-1:0] c_burst_max = c_cnt_w'(MAX_BURST);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

  owner_e               last_q, last_d;
  logic [c_cnt_w-1:0]   burst_cnt_q, burst_cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  owner_e               rd_owner_q, rd_owner_d;

  owner_e               gnt_owner;
  logic                 any_gnt;
  logic                 gnt_we;
  logic                 keep_last;

  // Arbitration: pick the owner for this cycle; nothing granted while in reset.
  always_comb begin
    gnt_owner = OWNER_CPU;
    any_gnt   = 1'b0;
    keep_last = (burst_cnt_q != '0) && (burst_cnt_q < c_burst_max);
    if (!rst) begin
      if (cpu_req && dbg_req) begin
        any_gnt = 1'b1;
        // Fresh contention or exhausted burst hands over; otherwise continue.
        if (keep_last) begin
          gnt_owner = last_q;
        end else begin
          gnt_owner = (last_q == OWNER_CPU) ? OWNER_DBG : OWNER_CPU;
        end
      end else if (cpu_req) begin
        any_gnt   = 1'b1;
        gnt_owner = OWNER_CPU;
      end else if (dbg_req) begin
        any_gnt   = 1'b1;
        gnt_owner = OWNER_DBG;
      end
    end
  end

  // Route the granted side onto the memory port; all zero when idle.
  always_comb begin
    cpu_gnt   = any_gnt && (gnt_owner == OWNER_CPU);
    dbg_gnt   = any_gnt && (gnt_owner == OWNER_DBG);
    mem_en    = any_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    gnt_we    = 1'b0;
    if (cpu_gnt) begin
      gnt_we    = cpu_we;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      gnt_we    = dbg_we;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Next state: burst tracking and read-return bookkeeping.
  always_comb begin
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    rd_pend_d   = 1'b0;
    rd_owner_d  = rd_owner_q;
    if (any_gnt) begin
      last_d = gnt_owner;
      if (gnt_owner == last_q) begin
        burst_cnt_d = (burst_cnt_q >= c_burst_max) ? c_burst_max : burst_cnt_q + c_cnt_one;
      end else begin
        burst_cnt_d = c_cnt_one;
      end
      if (!gnt_we) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = gnt_owner;
      end
    end else begin
      burst_cnt_d = '0;
    end
  end

  // State register; reset discards any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= OWNER_DBG;
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= OWNER_CPU;
    end else begin
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  // Read return: steer memory data to the side that issued last cycle's read.
  always_comb begin
    cpu_rvalid = !rst && rd_pend_q && (rd_owner_q == OWNER_CPU);
    dbg_rvalid = !rst && rd_pend_q && (rd_owner_q == OWNER_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_cpu_q, stat_cpu_d;
  logic [15:0] stat_dbg_q, stat_dbg_d;
  logic [15:0] stat_stall_q, stat_stall_d;
  logic        denied;

  // Saturating counters: grants per side and cycles with a denied requester.
  always_comb begin
    denied       = (cpu_req && !cpu_gnt) || (dbg_req && !dbg_gnt);
    stat_cpu_d   = stat_cpu_q;
    stat_dbg_d   = stat_dbg_q;
    stat_stall_d = stat_stall_q;
    if (cpu_gnt && (stat_cpu_q != 16'hFFFF)) begin
      stat_cpu_d = stat_cpu_q + 16'd1;
    end
    if (dbg_gnt && (stat_dbg_q != 16'hFFFF)) begin
      stat_dbg_d = stat_dbg_q + 16'd1;
    end
    if (denied && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cpu_q   <= '0;
      stat_dbg_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_cpu_q   <= stat_cpu_d;
      stat_dbg_q   <= stat_dbg_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_cpu   = stat_cpu_q;
  assign stat_dbg   = stat_dbg_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter: vector table plus
//            hand-written sequences, read data tracked through a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]   stat_cpu, stat_dbg, stat_stall;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_cpu   (stat_cpu),
    .stat_dbg   (stat_dbg),
    .stat_stall (stat_stall)
`endif
  );

  function automatic logic [DW-1:0] init_pat(input int a);
    logic [DW-1:0] v;
    v = (DW'(a) * 16'd3) ^ 16'hA5C3;
    if (a == 12'h01F) v = 16'hBEEF;
    return v;
  endfunction

  // Synchronous-read memory driven by the DUT's memory port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_pat(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct {
    logic          r;
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic          ecg, edg;
  } vec_t;

  typedef struct {
    logic          side;   // 0 = CPU, 1 = DBG
    logic [DW-1:0] data;
  } rd_t;

  vec_t          tbl[$];
  rd_t           sb[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic vec_t mk(input logic r,
                              input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                              input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                              input logic ecg, input logic edg);
    vec_t v;
    v.r = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ecg = ecg; v.edg = edg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (vector %0d, t=%0t)", name, act, expv, n_vec, $time);
    end
  endtask

  // Drive one cycle, check mid-cycle, update the reference model, advance.
  task automatic apply(input vec_t v);
    logic          ecv, edv, een, ewe;
    logic [DW-1:0] ecd, edd, ewd;
    logic [AW-1:0] ea;
    rd_t           e;
    rst = v.r;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    dbg_req = v.dr; dbg_we = v.dw; dbg_addr = v.da; dbg_wdata = v.dd;
    #4;
    n_vec++;
    ecv = 1'b0; edv = 1'b0; ecd = '0; edd = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!v.r) begin
        if (e.side == 1'b0) begin ecv = 1'b1; ecd = e.data; end
        else                begin edv = 1'b1; edd = e.data; end
      end
    end
    een = 1'b0; ewe = 1'b0; ea = '0; ewd = '0;
    if (v.ecg) begin een = 1'b1; ewe = v.cw; ea = v.ca; ewd = v.cd; end
    else if (v.edg) begin een = 1'b1; ewe = v.dw; ea = v.da; ewd = v.dd; end
    check("cpu_gnt",    32'(cpu_gnt),    32'(v.ecg));
    check("dbg_gnt",    32'(dbg_gnt),    32'(v.edg));
    check("mem_en",     32'(mem_en),     32'(een));
    check("mem_we",     32'(mem_we),     32'(ewe));
    check("mem_addr",   32'(mem_addr),   32'(ea));
    check("mem_wdata",  32'(mem_wdata),  32'(ewd));
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(ecv));
    check("cpu_rdata",  32'(cpu_rdata),  32'(ecd));
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(edv));
    check("dbg_rdata",  32'(dbg_rdata),  32'(edd));
    if (v.r) begin
      sb.delete();
    end else if (een) begin
      if (ewe) begin
        ref_mem[ea] = ewd;
      end else begin
        e.side = v.edg;
        e.data = ref_mem[ea];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_pat(i);
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    //            rst cr cw ca       cd        dr dw da       dd        ecg edg
    tbl.push_back(mk(1, 0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 12'h01F, 16'h0000, 0, 0, 12'h000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 16'h0000, 1, 1, 12'h123, 16'h5A5A, 0, 1));
    tbl.push_back(mk(0, 1, 0, 12'h123, 16'h0000, 0, 0, 12'h000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 1, 0, 12'h010, 16'h0000, 0, 0, 12'h000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 16'h0000, 1, 0, 12'h011, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 0, 12'h010, 16'h0000, 0, 0, 12'h000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 16'h0000, 1, 0, 12'h011, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 12'h020, 16'h0000, 1, 0, 12'h021, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 1, 0, 12'h020, 16'h0000, 1, 0, 12'h021, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 16'h0000, 1, 0, 12'h021, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 12'h200, 16'h1234, 0, 0, 12'h000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 16'h0000, 1, 0, 12'h200, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

    // Reset with both requesting, then sustained contention: C,C,C,C,D,D,D,D,C.
    apply(mk(1, 1, 0, 12'h030, 16'h0000, 1, 0, 12'h031, 16'h0000, 0, 0));
    for (int i = 0; i < 9; i++) begin
      logic c;
      c = (i < 4) || (i == 8);
      apply(mk(0, 1, 0, 12'h030, 16'h0000, 1, 0, 12'h031, 16'h0000, c, !c));
    end
    apply(mk(0, 0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 0));

    // Read grant, reset the next cycle: read dropped, CPU wins the next contention.
    apply(mk(0, 0, 0, 12'h000, 16'h0000, 1, 0, 12'h040, 16'h0000, 0, 1));
    apply(mk(1, 1, 0, 12'h041, 16'h0000, 1, 0, 12'h040, 16'h0000, 0, 0));
    apply(mk(0, 1, 0, 12'h041, 16'h0000, 1, 0, 12'h040, 16'h0000, 1, 0));
    apply(mk(0, 0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 0));

`ifdef MEM_ARB_STATS_EN
    apply(mk(1, 0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 0));
    n_vec++;
    check("stat_reset", 32'({stat_cpu, stat_dbg} | {16'h0, stat_stall}), 32'h0);
    for (int i = 0; i < 10; i++) begin
      logic c;
      c = (i < 4) || (i >= 8);
      apply(mk(0, 1, 1, 12'h3F0, 16'h1111, 1, 1, 12'h3F1, 16'h2222, c, !c));
    end
    n_vec++;
    check("stat_grants", 32'(stat_cpu) + 32'(stat_dbg), 32'd10);
    n_vec++;
    check("stat_stall", 32'(stat_stall), 32'd10);
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
    end
    #1;
    n_vec++;
    check("stat_stall_sat", 32'(stat_stall), 32'hFFFF);
    sb.delete();
    apply(mk(1, 0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
